async_link_arb: RTL and testbench

ASYNC_LINK_ARB -- requirements
Module: async_link_arb

---
 rtl/async_pkg.sv | 16 +
 rtl/sync_2ff.sv | 24 ++
 rtl/async_link_arb.sv | 148 ++++++++++++++
 tb/tb_async_link_arb.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_pkg.sv
// Shared constants and FSM state type for the async link arbiter.
// Rail indices select the true/false wire of each dual-rail bit.
`timescale 1ns/1ps
package async_pkg;

  localparam int RAIL_NUM = 2;
  localparam int RAIL_T   = 1;
  localparam int RAIL_F   = 0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous two-phase ack.
// Both flops clear on the synchronous reset.
`timescale 1ns/1ps
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async level through two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/async_link_arb.sv
// Round-robin arbiter driving a dual-rail two-phase async link.
// Optional ack watchdog: define ASYNC_LINK_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
import async_pkg::*;

module async_link_arb #(
  parameter int WIDTH   = 8,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255,
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][WIDTH-1:0]       req_data,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [WIDTH-1:0][RAIL_NUM-1:0]      out,
  input  logic                                ack_i,
  output logic                                busy,
  output logic [GW-1:0]                       grant_id,
  output logic                                err
);

  state_t           state;
  state_t           state_nx;
  logic [GW-1:0]    last_grant;
  logic [GW-1:0]    pick;
  logic [GW-1:0]    pick_hi;
  logic [GW-1:0]    pick_lo;
  logic             hit_hi;
  logic             hit_lo;
  logic             hit;
  logic [WIDTH-1:0] data_q;
  logic             phase;
  logic             ack_s;
  logic             ack_off;
  logic             ack_hit;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ack_i),
    .q   (ack_s)
  );

  // ack_off absorbs toggles seen in IDLE so a stray
  // ack can never satisfy the next token's wait.
  assign ack_hit = ((ack_s ^ ack_off) == phase);
  assign busy    = (state != IDLE);

  // Round-robin pick: lowest index above last_grant,
  // else wrap to the lowest valid index.
  always_comb begin
    pick_hi = '0;
    pick_lo = '0;
    hit_hi  = 1'b0;
    hit_lo  = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (GW'(i) > last_grant) begin
          pick_hi = GW'(i);
          hit_hi  = 1'b1;
        end else begin
          pick_lo = GW'(i);
          hit_lo  = 1'b1;
        end
      end
    end
    pick = hit_hi ? pick_hi : pick_lo;
    hit  = hit_hi | hit_lo;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and the one-hot accept strobe.
  always_comb begin
    state_nx  = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (hit && !rst) begin
          req_ready[pick] = 1'b1;
          state_nx        = SEND;
        end
      end
      SEND:    state_nx = WAIT;
      WAIT:    if (ack_hit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch the winner and toggle one rail per bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      data_q     <= '0;
      out        <= '0;
      phase      <= 1'b0;
      ack_off    <= 1'b0;
    end else begin
      if (state == IDLE) ack_off <= ack_s ^ phase;
      if (|req_ready) begin
        last_grant <= pick;
        grant_id   <= pick;
        data_q     <= req_data[pick];
      end
      if (state == SEND) begin
        phase <= ~phase;
        for (int i = 0; i < WIDTH; i++) begin
          out[i][RAIL_T] <= out[i][RAIL_T] ^ data_q[i];
          out[i][RAIL_F] <= out[i][RAIL_F] ^ ~data_q[i];
        end
      end
    end
  end

`ifdef ASYNC_LINK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wait_cnt;

  // Ack watchdog: sticky err after TIMEOUT WAIT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err      <= 1'b0;
    end else if (state == SEND) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      if (wait_cnt != CW'(TIMEOUT))
        wait_cnt <= wait_cnt + 1'b1;
      if (wait_cnt == CW'(TIMEOUT - 1))
        err <= 1'b1;
    end
  end
`else
  logic timeout_unused;

  assign timeout_unused = (TIMEOUT != 0);
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_async_link_arb.sv
// Randomized self-checking bench for async_link_arb.
// Reference: XOR rail accumulation plus round-robin rule.
`timescale 1ns/1ps
module tb_async_link_arb;
  import async_pkg::*;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int TO = 16;
`ifdef ASYNC_LINK_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic [N-1:0]        req_valid;
  logic [N-1:0][W-1:0] req_data;
  logic [N-1:0]        req_ready;
  logic [W-1:0][1:0]   out;
  logic                ack_i;
  logic                busy;
  logic [1:0]          grant_id;
  logic                err;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] exp_t;
  logic [W-1:0] exp_f;
  int           last;

  async_link_arb #(
    .WIDTH   (W),
    .NUM_REQ (N),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out       (out),
    .ack_i     (ack_i),
    .busy      (busy),
    .grant_id  (grant_id),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] pack(
    input logic [W-1:0] t,
    input logic [W-1:0] f
  );
    logic [2*W-1:0] r;
    for (int i = 0; i < W; i++) begin
      r[2*i+1] = t[i];
      r[2*i]   = f[i];
    end
    return r;
  endfunction

  function automatic int rr(input int lst, input logic [N-1:0] m);
    for (int k = 1; k <= N; k++) begin
      if (m[(lst + k) % N]) return (lst + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    ack_i     = 1'b0;
    for (int i = 0; i < N; i++) req_data[i] = W'($urandom);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst   = 1'b0;
    exp_t = '0;
    exp_f = '0;
    last  = N - 1;
  endtask

  // Plays the downstream stage: waits for accept, then acks.
  task automatic serve(
    input  int             ack_dly,
    output bit             got,
    output logic [N-1:0]   rdy,
    output logic [2*W-1:0] o_new,
    output bit             leak,
    output bit             early,
    output int             lat
  );
    got   = 1'b0;
    rdy   = '0;
    o_new = '0;
    leak  = 1'b0;
    early = 1'b0;
    lat   = 99;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != '0) begin
        got = 1'b1;
        rdy = req_ready;
        break;
      end
      @(negedge clk);
    end
    if (!got) return;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    o_new = out;
    for (int i = 0; i < ack_dly; i++) begin
      if (req_ready != '0) leak = 1'b1;
      if (!busy) early = 1'b1;
      @(negedge clk);
    end
    ack_i = ~ack_i;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (!busy) begin
        lat = i;
        break;
      end
    end
  endtask

  // One full token against the reference model.
  task automatic token_check(input string tag, input int dly);
    bit             got;
    bit             leak;
    bit             early;
    int             lat;
    int             g;
    logic [N-1:0]   rdy;
    logic [N-1:0]   oh;
    logic [2*W-1:0] o_new;
    logic [2*W-1:0] o_exp;
    logic [W-1:0]   d;
    g     = rr(last, req_valid);
    d     = req_data[g];
    oh    = '0;
    oh[g] = 1'b1;
    o_exp = pack(exp_t ^ d, exp_f ^ ~d);
    serve(dly, got, rdy, o_new, leak, early, lat);
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s accept: no ready within bound", tag);
      return;
    end
    n_cmp++;
    if (rdy !== oh) begin
      n_bad++;
      $display("FAIL %s ready: got %b want %b", tag, rdy, oh);
    end
    n_cmp++;
    if (grant_id !== 2'(g)) begin
      n_bad++;
      $display("FAIL %s grant_id: got %0d want %0d", tag, grant_id, g);
    end
    n_cmp++;
    if (o_new !== o_exp) begin
      n_bad++;
      $display("FAIL %s rails: got %h want %h", tag, o_new, o_exp);
    end
    n_cmp++;
    if (leak || early) begin
      n_bad++;
      $display("FAIL %s wait: leak %0d early %0d want 0 0",
               tag, leak, early);
    end
    n_cmp++;
    if (lat < 1 || lat > 3) begin
      n_bad++;
      $display("FAIL %s busy_drop: got %0d want 1..3", tag, lat);
    end
    exp_t = exp_t ^ d;
    exp_f = exp_f ^ ~d;
    last  = g;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (out !== '0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want 0", out);
    end
    n_cmp++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flags: busy %b err %b want 0 0", busy, err);
    end
    n_cmp++;
    if (grant_id !== 2'd0 || req_ready !== '0) begin
      n_bad++;
      $display("FAIL reset_grant: id %0d ready %b want 0 0",
               grant_id, req_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    do_reset();
    req_data[0] = 8'hA5;
    req_valid   = 4'b0001;
    token_check("single", 5);
    req_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    req_valid = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      token_check("rr", int'($urandom_range(1, 6)));
      req_data[last] = W'($urandom);
    end
    req_valid = '0;
  endtask

  task automatic test_phase();
    do_reset();
    req_data[0] = 8'hFF;
    req_valid   = 4'b0001;
    token_check("phase1", 8);
    n_cmp++;
    if (out !== 16'hAAAA) begin
      n_bad++;
      $display("FAIL phase1_out: got %h want aaaa", out);
    end
    token_check("phase2", 3);
    n_cmp++;
    if (out !== 16'h0000) begin
      n_bad++;
      $display("FAIL phase2_out: got %h want 0000", out);
    end
    req_valid = '0;
  endtask

  task automatic test_spurious();
    ack_i = ~ack_i;
    repeat (6) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || out !== pack(exp_t, exp_f)) begin
      n_bad++;
      $display("FAIL spurious_idle: busy %b out %h want 0 %h",
               busy, out, pack(exp_t, exp_f));
    end
    req_data[1] = 8'h01;
    req_valid   = 4'b0010;
    token_check("spurious", 6);
    req_valid = '0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      token_check("random", int'($urandom_range(1, 6)));
      req_data[last] = W'($urandom);
    end
    req_valid = '0;
  endtask

  task automatic test_timeout_reset();
    bit got;
    do_reset();
    req_data[0] = 8'h3C;
    req_valid   = 4'b0001;
    got         = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL tmo_accept: no ready within bound");
    end
    @(posedge clk);
    for (int k = 0; k <= 17; k++) begin
      @(negedge clk);
      if (k == 16) begin
        n_cmp++;
        if (err !== 1'b0) begin
          n_bad++;
          $display("FAIL tmo_early: err %b want 0", err);
        end
      end
      if (k == 17) begin
        n_cmp++;
        if (err !== TEN) begin
          n_bad++;
          $display("FAIL tmo_rise: err %b want %b", err, TEN);
        end
      end
    end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (err !== TEN || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_hold: err %b busy %b want %b 1",
               err, busy, TEN);
    end
    rst   = 1'b1;
    ack_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out !== '0 || busy !== 1'b0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_wait: out %h busy %b err %b want 0 0 0",
               out, busy, err);
    end
    n_cmp++;
    if (grant_id !== 2'd0) begin
      n_bad++;
      $display("FAIL rst_grant: got %0d want 0", grant_id);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL rst_ready: got %b want 0001", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_phase();
    test_spurious();
    test_random();
    test_timeout_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
